// File: rtl/signed_divider.sv
// Signed integer divider: 32-bit dividend by 16-bit divisor, restoring shift-subtract, one quotient bit per clock.
// Latency: 33 cycles from the accepting edge to done, fixed for every operand including divide-by-zero.
// Backpressure: none; start is sampled only in IDLE and ignored while busy (no queueing).
module signed_divider #(
  parameter int WIDTH_N = 32,
  parameter int WIDTH_D = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CW = $clog2(WIDTH_N);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  // Holds the dividend magnitude; quotient bits shift in from the bottom as it shifts out the top.
  logic [WIDTH_N-1:0] dvd_q;
  logic [WIDTH_D-1:0] dvs_mag;
  logic [WIDTH_D:0]   prem;
  logic [CW-1:0]      cnt;
  logic               dvd_neg;
  logic               dvs_neg;
  logic               ovf_case;

  // One extra bit beyond the partial remainder so the trial result's sign is never lost.
  logic [WIDTH_D+1:0] shifted;
  logic [WIDTH_D+1:0] trial;
  logic [WIDTH_N-1:0] dvd_abs;
  logic [WIDTH_D-1:0] dvs_abs;
  logic               is_ovf;
  logic [WIDTH_D-1:0] rmag;

  assign shifted = {prem, dvd_q[WIDTH_N-1]};
  assign trial   = shifted - {2'b00, dvs_mag};
  // Negating the most negative value wraps to itself, which read unsigned is the correct magnitude.
  assign dvd_abs = dividend[WIDTH_N-1] ? -dividend : dividend;
  assign dvs_abs = divisor[WIDTH_D-1]  ? -divisor  : divisor;
  assign is_ovf  = (dividend == {1'b1, {(WIDTH_N-1){1'b0}}}) && (divisor == {WIDTH_D{1'b1}});
  // The partial remainder is always below |divisor| <= 2^(WIDTH_D-1), so the low bits carry it.
  assign rmag    = prem[WIDTH_D-1:0];

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      dvd_q       <= '0;
      dvs_mag     <= '0;
      prem        <= '0;
      cnt         <= '0;
      dvd_neg     <= 1'b0;
      dvs_neg     <= 1'b0;
      ovf_case    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CALC;
            busy     <= 1'b1;
            dvd_neg  <= dividend[WIDTH_N-1];
            dvs_neg  <= divisor[WIDTH_D-1];
            ovf_case <= is_ovf;
            dvd_q    <= dvd_abs;
            dvs_mag  <= dvs_abs;
            prem     <= '0;
            cnt      <= '0;
          end
        end
        CALC: begin
          // Keep the difference when non-negative (quotient bit 1), otherwise restore.
          dvd_q <= {dvd_q[WIDTH_N-2:0], ~trial[WIDTH_D+1]};
          prem  <= trial[WIDTH_D+1] ? shifted[WIDTH_D:0] : trial[WIDTH_D:0];
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH_N-1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (dvs_mag == '0) begin
            // Iterations ran anyway to keep latency constant; their result is meaningless.
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            // Min / -1: magnitude 2^(N-1) with equal signs is left as-is and reads back wrapped.
            quotient    <= (dvd_neg ^ dvs_neg) ? -dvd_q : dvd_q;
            remainder   <= dvd_neg ? -rmag : rmag;
            div_by_zero <= 1'b0;
            overflow    <= ovf_case;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
